mpeg_video_packet_demux: RTL and testbench

Byte-serial MPEG-1 system-stream demultiplexer that sits directly upstream of the video start code decoder. It parses pack headers, system headers and packet headers, and forwards only the payload bytes of one selected video stream. It emits each payload byte on `mpeg_data`/`data_valid`, which connect straight to the video start code decoder. It also extracts the presentation timestamp (PTS) of each video packet for A/V sync logic downstream.

---
 rtl/mpeg_system_pkg.sv | 28 ++
 rtl/mpeg_timestamp_parser.sv | 74 +++++++
 rtl/mpeg_video_packet_demux.sv | 215 +++++++++++++++++++++
 tb/tb_mpeg_video_packet_demux.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpeg_system_pkg.sv
// Shared definitions for the MPEG-1 system-stream parsing blocks.
package mpeg_system_pkg;

    typedef enum logic [3:0] {
        S_SYNC,
        S_Z1,
        S_Z2,
        S_ID,
        S_PACK,
        S_LEN_HI,
        S_LEN_LO,
        S_HDR,
        S_STD1,
        S_TS,
        S_PAYLOAD,
        S_SKIP
    } state_e;

    localparam logic [7:0] SC_PACK   = 8'hBA;
    localparam logic [7:0] SC_SYSHDR = 8'hBB;
    localparam logic [7:0] SC_END    = 8'hB9;

    // Maximum number of 0xFF stuffing bytes tolerated in a packet header
    localparam int unsigned STUFF_LIMIT = 16;
    // Bytes in an MPEG-1 pack header body after the 0xBA start code
    localparam int unsigned PACK_LEN = 8;

endpackage

// File: rtl/mpeg_timestamp_parser.sv
// Assembles a 33-bit MPEG timestamp from its 5-byte encoding and checks the
// marker bits of bytes 1, 3 and 5. Used for PTS now and SCR later.
module mpeg_timestamp_parser (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  ts_byte,
    input  logic        ts_strobe,
    input  logic        ts_first,   // this strobe carries byte 1 of a new timestamp
    output logic [32:0] ts_value,
    output logic        ts_done,    // 5th byte consumed and every marker was good
    output logic        ts_error    // marker bit of the current byte is bad
);

    logic [2:0]  idx_q, idx_d;
    logic [32:0] acc_q, acc_d;
    logic        bad_q, bad_d;

    logic [2:0]  idx;
    logic [32:0] acc_nxt;
    logic        bad_in;
    logic        marker_bad;

    // Merge the current byte into the running value and flag marker faults
    always_comb begin
        idx        = ts_first ? 3'd0 : idx_q;
        acc_nxt    = ts_first ? 33'd0 : acc_q;
        bad_in     = ts_first ? 1'b0 : bad_q;
        marker_bad = 1'b0;
        case (idx)
            3'd0: begin
                acc_nxt[32:30] = ts_byte[3:1];
                marker_bad     = ~ts_byte[0];
            end
            3'd1: acc_nxt[29:22] = ts_byte;
            3'd2: begin
                acc_nxt[21:15] = ts_byte[7:1];
                marker_bad     = ~ts_byte[0];
            end
            3'd3: acc_nxt[14:7] = ts_byte;
            3'd4: begin
                acc_nxt[6:0] = ts_byte[7:1];
                marker_bad   = ~ts_byte[0];
            end
            default: ;
        endcase

        idx_d = idx_q;
        acc_d = acc_q;
        bad_d = bad_q;
        if (ts_strobe && idx < 3'd5) begin
            idx_d = idx + 3'd1;
            acc_d = acc_nxt;
            bad_d = bad_in | marker_bad;
        end

        ts_value = acc_nxt;
        ts_error = ts_strobe && (idx < 3'd5) && marker_bad;
        ts_done  = ts_strobe && (idx == 3'd4) && !(bad_in || marker_bad);
    end

    // Timestamp accumulator state
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= 3'd0;
            acc_q <= 33'd0;
            bad_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            acc_q <= acc_d;
            bad_q <= bad_d;
        end
    end

endmodule

// File: rtl/mpeg_video_packet_demux.sv
// MPEG-1 system-stream demultiplexer: tracks pack/system/packet headers and
// forwards the payload of one selected stream, capturing its PTS.
module mpeg_video_packet_demux
    import mpeg_system_pkg::*;
#(
    parameter logic [7:0] STREAM_ID = 8'hE0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic [7:0]  mpeg_data,
    output logic        data_valid,
    output logic [32:0] pts,
    output logic        pts_valid,
    output logic        end_of_stream,
    output logic        format_error
);

    state_e      state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [7:0]  id_q, id_d;
    logic [3:0]  cnt_q, cnt_d;        // bytes left in PACK or TS
    logic        ts_dts_q, ts_dts_d;  // TS field carries a trailing DTS
    logic [4:0]  stuff_q, stuff_d;

    logic [7:0]  mpeg_data_q, mpeg_data_d;
    logic        data_valid_q, data_valid_d;
    logic [32:0] pts_q, pts_d;
    logic        pts_valid_q, pts_valid_d;
    logic        eos_q, eos_d;
    logic        ferr_q, ferr_d;

    logic        ts_strobe, ts_first, ts_done, ts_error;
    logic [32:0] ts_value;

    // Feed PTS bytes (not DTS bytes) to the timestamp assembler
    always_comb begin
        ts_first  = (state_q == S_HDR);
        ts_strobe = din_valid &&
                    ((state_q == S_HDR && din[7:5] == 3'b001) ||
                     (state_q == S_TS && (!ts_dts_q || cnt_q > 4'd5)));
    end

    mpeg_timestamp_parser u_pts (
        .clk       (clk),
        .reset     (reset),
        .ts_byte   (din),
        .ts_strobe (ts_strobe),
        .ts_first  (ts_first),
        .ts_value  (ts_value),
        .ts_done   (ts_done),
        .ts_error  (ts_error)
    );

    // Parser next state and registered-output values
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        len_hi_d     = len_hi_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        ts_dts_d     = ts_dts_q;
        stuff_d      = stuff_q;
        mpeg_data_d  = mpeg_data_q;
        data_valid_d = 1'b0;
        pts_d        = pts_q;
        pts_valid_d  = 1'b0;
        eos_d        = 1'b0;
        ferr_d       = 1'b0;

        if (din_valid) begin
            case (state_q)
                S_SYNC: state_d = (din == 8'h00) ? S_Z1 : S_SYNC;
                S_Z1:   state_d = (din == 8'h00) ? S_Z2 : S_SYNC;
                S_Z2: begin
                    if (din == 8'h00)      state_d = S_Z2;
                    else if (din == 8'h01) state_d = S_ID;
                    else                   state_d = S_SYNC;
                end
                S_ID: begin
                    id_d = din;
                    if (din == SC_PACK) begin
                        state_d = S_PACK;
                        cnt_d   = 4'(PACK_LEN);
                    end else if (din == SC_END) begin
                        eos_d   = 1'b1;
                        state_d = S_SYNC;
                    end else if (din == SC_SYSHDR || din >= 8'hBC) begin
                        state_d = S_LEN_HI;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_SYNC;
                    end
                end
                S_PACK: begin
                    // MPEG-2 packs start with 01xx_xxxx and are rejected here
                    if (cnt_q == 4'(PACK_LEN) && (din[7:4] != 4'b0010 || !din[0])) begin
                        ferr_d  = 1'b1;
                        state_d = S_SYNC;
                    end else if (cnt_q == 4'd1) begin
                        state_d = S_SYNC;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_LEN_HI: begin
                    len_hi_d = din;
                    state_d  = S_LEN_LO;
                end
                S_LEN_LO: begin
                    remaining_d = {len_hi_q, din};
                    stuff_d     = 5'd0;
                    if ({len_hi_q, din} == 16'd0)                  state_d = S_SYNC;
                    else if (id_q != STREAM_ID || id_q == SC_SYSHDR) state_d = S_SKIP;
                    else                                           state_d = S_HDR;
                end
                S_HDR: begin
                    if (din == 8'hFF) begin
                        if (stuff_q == 5'(STUFF_LIMIT)) begin
                            ferr_d  = 1'b1;
                            state_d = S_SYNC;
                        end else begin
                            stuff_d = stuff_q + 5'd1;
                        end
                    end else if (din[7:6] == 2'b01) begin
                        state_d = S_STD1;
                    end else if (din[7:4] == 4'b0010) begin
                        state_d  = S_TS;
                        cnt_d    = 4'd4;
                        ts_dts_d = 1'b0;
                    end else if (din[7:4] == 4'b0011) begin
                        state_d  = S_TS;
                        cnt_d    = 4'd9;
                        ts_dts_d = 1'b1;
                    end else if (din == 8'h0F) begin
                        state_d = S_PAYLOAD;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_SYNC;
                    end
                end
                S_STD1: state_d = S_HDR;
                S_TS: begin
                    // In MPEG-1 the payload follows the timestamps directly
                    if (cnt_q == 4'd1) state_d = S_PAYLOAD;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                S_PAYLOAD: begin
                    mpeg_data_d  = din;
                    data_valid_d = 1'b1;
                end
                S_SKIP: ;
                default: state_d = S_SYNC;
            endcase

            if (ts_error) ferr_d = 1'b1;
            if (ts_done) begin
                pts_d       = ts_value;
                pts_valid_d = 1'b1;
            end

            // Packet length bounds everything after the length field
            if (state_q inside {S_HDR, S_STD1, S_TS, S_PAYLOAD, S_SKIP}) begin
                remaining_d = remaining_q - 16'd1;
                if (remaining_q == 16'd1) begin
                    state_d = S_SYNC;
                    if (state_q inside {S_HDR, S_STD1, S_TS}) ferr_d = 1'b1;
                end
            end
        end
    end

    // Parser state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_SYNC;
            remaining_q  <= 16'd0;
            len_hi_q     <= 8'd0;
            id_q         <= 8'd0;
            cnt_q        <= 4'd0;
            ts_dts_q     <= 1'b0;
            stuff_q      <= 5'd0;
            mpeg_data_q  <= 8'd0;
            data_valid_q <= 1'b0;
            pts_q        <= 33'd0;
            pts_valid_q  <= 1'b0;
            eos_q        <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            len_hi_q     <= len_hi_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            ts_dts_q     <= ts_dts_d;
            stuff_q      <= stuff_d;
            mpeg_data_q  <= mpeg_data_d;
            data_valid_q <= data_valid_d;
            pts_q        <= pts_d;
            pts_valid_q  <= pts_valid_d;
            eos_q        <= eos_d;
            ferr_q       <= ferr_d;
        end
    end

    assign mpeg_data     = mpeg_data_q;
    assign data_valid    = data_valid_q;
    assign pts           = pts_q;
    assign pts_valid     = pts_valid_q;
    assign end_of_stream = eos_q;
    assign format_error  = ferr_q;

endmodule

// File: tb/tb_mpeg_video_packet_demux.sv
// Scoreboard bench for mpeg_video_packet_demux: directed byte streams push
// their hand-computed output events; a negedge monitor pops and compares.
module tb_mpeg_video_packet_demux;

    localparam int K_DATA = 0;
    localparam int K_PTS  = 1;
    localparam int K_EOS  = 2;
    localparam int K_FERR = 3;

    typedef struct {
        int          kind;
        logic [32:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  din;
    logic        din_valid;
    logic [7:0]  mpeg_data;
    logic        data_valid;
    logic [32:0] pts;
    logic        pts_valid;
    logic        end_of_stream;
    logic        format_error;

    exp_t       exp_q[$];
    logic [7:0] stim[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         gap_mode = 1'b0;

    mpeg_video_packet_demux #(.STREAM_ID(8'hE0)) dut (
        .clk           (clk),
        .reset         (reset),
        .din           (din),
        .din_valid     (din_valid),
        .mpeg_data     (mpeg_data),
        .data_valid    (data_valid),
        .pts           (pts),
        .pts_valid     (pts_valid),
        .end_of_stream (end_of_stream),
        .format_error  (format_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input int k, input logic [32:0] v, input string nm);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected output value=%0h, none required", nm, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                n_fail++;
                $display("FAIL %s: got kind=%0d value=%0h, required kind=%0d value=%0h",
                         nm, k, v, e.kind, e.val);
            end
        end
    endtask

    task automatic check_eq(input string nm, input logic [32:0] act, input logic [32:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Monitor: every asserted output strobe must match the next expectation
    always @(negedge clk) begin
        if (data_valid)    chk(K_DATA, {25'd0, mpeg_data}, "data");
        if (pts_valid)     chk(K_PTS, pts, "pts");
        if (end_of_stream) chk(K_EOS, 33'd0, "eos");
        if (format_error)  chk(K_FERR, 33'd0, "format_error");
    end

    task automatic expect_ev(input int k, input logic [32:0] v);
        exp_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic idle_cycle();
        din       = 8'h00;
        din_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_stim();
        foreach (stim[i]) begin
            if (gap_mode) begin
                int n = $urandom_range(0, 2);
                repeat (n) idle_cycle();
            end
            din       = stim[i];
            din_valid = 1'b1;
            @(posedge clk);
            #1;
            din_valid = 1'b0;
            din       = 8'h00;
        end
    endtask

    task automatic drain(input string nm);
        repeat (4) idle_cycle();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected outputs missing, required 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic send_pack();
        stim = '{8'h00, 8'h00, 8'h01, 8'hBA, 8'h21, 8'h00, 8'h01, 8'h00,
                 8'h01, 8'h80, 8'h00, 8'h01};
        run_stim();
    endtask

    task automatic basic_test();
        send_pack();
        expect_ev(K_DATA, 33'hAA); expect_ev(K_DATA, 33'hBB); expect_ev(K_DATA, 33'hCC);
        expect_ev(K_DATA, 33'hDD); expect_ev(K_DATA, 33'hEE); expect_ev(K_DATA, 33'hFF);
        stim = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h07, 8'h0F,
                 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        run_stim();
    endtask

    task automatic pts_test();
        expect_ev(K_PTS, 33'd32770);
        expect_ev(K_DATA, 33'h12); expect_ev(K_DATA, 33'h34);
        stim = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h07,
                 8'h21, 8'h00, 8'h03, 8'h00, 8'h05, 8'h12, 8'h34};
        run_stim();
    endtask

    initial begin
        reset     = 1'b1;
        din       = 8'h00;
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset mpeg_data", {25'd0, mpeg_data}, 33'd0);
        check_eq("reset data_valid", {32'd0, data_valid}, 33'd0);
        check_eq("reset pts", pts, 33'd0);
        check_eq("reset pts_valid", {32'd0, pts_valid}, 33'd0);
        check_eq("reset end_of_stream", {32'd0, end_of_stream}, 33'd0);
        check_eq("reset format_error", {32'd0, format_error}, 33'd0);
        reset = 1'b0;
        idle_cycle();

        basic_test();
        drain("basic");

        pts_test();
        drain("pts");

        // Bad marker in byte 3: error, pts keeps 32770, payload still forwarded
        expect_ev(K_FERR, 33'd0);
        expect_ev(K_DATA, 33'h56); expect_ev(K_DATA, 33'h78);
        stim = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h07,
                 8'h21, 8'h00, 8'h02, 8'h00, 8'h07, 8'h56, 8'h78};
        run_stim();
        drain("pts marker");
        check_eq("pts after bad marker", pts, 33'd32770);

        // PTS+DTS: DTS bytes discarded, PTS = 5
        expect_ev(K_PTS, 33'd5);
        expect_ev(K_DATA, 33'h9A);
        stim = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h0B,
                 8'h31, 8'h00, 8'h01, 8'h00, 8'h0B,
                 8'h11, 8'h00, 8'h01, 8'h00, 8'h01, 8'h9A};
        run_stim();
        drain("pts dts");

        // Other stream skipped, selected stream right behind it forwarded
        expect_ev(K_DATA, 33'h5A); expect_ev(K_DATA, 33'hA5);
        stim = '{8'h00, 8'h00, 8'h01, 8'hE1, 8'h00, 8'h0A,
                 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A,
                 8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h03, 8'h0F, 8'h5A, 8'hA5};
        run_stim();
        drain("filter");

        // Stuffing plus STD field
        expect_ev(K_DATA, 33'h11);
        stim = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h07,
                 8'hFF, 8'hFF, 8'hFF, 8'h40, 8'h20, 8'h0F, 8'h11};
        run_stim();
        drain("stuffing");

        // 17 stuffing bytes: error, then re-sync on the next packet
        expect_ev(K_FERR, 33'd0);
        expect_ev(K_DATA, 33'h77);
        stim = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h20};
        for (int i = 0; i < 17; i++) stim.push_back(8'hFF);
        stim.push_back(8'h00); stim.push_back(8'h00); stim.push_back(8'h01);
        stim.push_back(8'hE0); stim.push_back(8'h00); stim.push_back(8'h02);
        stim.push_back(8'h0F); stim.push_back(8'h77);
        run_stim();
        drain("over stuffing");

        // Zero-length packet, system header skip, then a normal packet
        expect_ev(K_DATA, 33'h42);
        stim = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h01, 8'hBB, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03,
                 8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h02, 8'h0F, 8'h42};
        run_stim();
        drain("zero len");

        // Length runs out inside the header
        expect_ev(K_FERR, 33'd0);
        stim = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h02, 8'hFF, 8'hFF};
        run_stim();
        drain("short header");

        // MPEG-2 pack rejected
        expect_ev(K_FERR, 33'd0);
        stim = '{8'h00, 8'h00, 8'h01, 8'hBA, 8'h44};
        run_stim();
        drain("mpeg2 pack");

        // End code and an illegal system-level code
        expect_ev(K_EOS, 33'd0);
        expect_ev(K_FERR, 33'd0);
        stim = '{8'h00, 8'h00, 8'h01, 8'hB9, 8'h00, 8'h00, 8'h01, 8'hB3};
        run_stim();
        drain("termination");

        // Same streams with random idle gaps
        gap_mode = 1'b1;
        basic_test();
        pts_test();
        drain("gaps");
        gap_mode = 1'b0;

        // Reset in the middle of a payload
        expect_ev(K_DATA, 33'h21); expect_ev(K_DATA, 33'h22); expect_ev(K_DATA, 33'h23);
        stim = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h0B, 8'h0F, 8'h21, 8'h22, 8'h23};
        run_stim();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("pts after reset", pts, 33'd0);
        stim = '{8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29, 8'h2A};
        run_stim();
        drain("reset mid payload");
        expect_ev(K_DATA, 33'h99);
        send_pack();
        stim = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h02, 8'h0F, 8'h99};
        run_stim();
        drain("after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
